// File: rtl/lsu_mem_port.sv
// -----------------------------------------------------------------------------
// lsu_mem_port
//
// Load/store unit between the execute stage and the single-port, 16-bit-word
// data memory. One request at a time is taken over a valid/ready handshake.
// The unit forms the effective address, drives the memory pins, and returns
// formatted load data or a misalignment error. The memory has no byte
// enables, so byte stores are done as a read-modify-write.
//
// Ports:
//   clk, rst_n          rising-edge clock (shared with memory), async active-low reset
//   req_valid/req_ready request handshake, accepted when both high at clk edge
//   req_we              1 = store, 0 = load
//   req_size            0 = byte, 1 = halfword (full word)
//   req_unsigned        byte loads zero-extend when 1, sign-extend when 0
//   req_base/req_offset effective address = base + offset (carry dropped)
//   req_wdata           store data (byte stores use [7:0])
//   resp_valid          one-cycle response strobe
//   resp_rdata          formatted load data, 0 for stores/errors, held between responses
//   resp_err            misaligned halfword access
//   mem_addr            memory word address (ea >> 1)
//   mem_wdata           memory write data
//   mem_we, mem_re      memory write / read enables, decoded from state
//   mem_rdata           combinational memory read data
// -----------------------------------------------------------------------------
module lsu_mem_port #(
    parameter int WIDTH = 16,
    parameter int AW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic             req_size,
    input  logic             req_unsigned,
    input  logic [AW-1:0]    req_base,
    input  logic [AW-1:0]    req_offset,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    output logic             mem_re,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    logic [AW-1:0]    ea;
    logic [AW-1:0]    word_addr;
    logic             accept;

    // Request attributes captured at acceptance; only the low byte of the
    // store data is needed later because halfword stores load mem_wdata directly.
    logic             lat_we;
    logic             lat_size;
    logic             lat_unsigned;
    logic             lat_lane;
    logic [7:0]       lat_wbyte;

    logic [7:0]       rd_byte;
    logic [WIDTH-1:0] load_fmt;
    logic [WIDTH-1:0] merged;

    // Effective address wraps modulo 2^AW; the memory is word addressed.
    assign ea        = req_base + req_offset;
    assign word_addr = {1'b0, ea[AW-1:1]};
    assign accept    = req_valid & req_ready;

    // Handshake, strobe and memory enables are pure decodes of the state
    // register, so they drop immediately when reset is asserted.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign mem_re     = (state == READ);
    assign mem_we     = (state == WRITE);

    // Format the word coming back from memory: pick the little-endian byte
    // lane for byte accesses and extend it, and build the read-modify-write
    // word for byte stores by replacing just the selected lane.
    always_comb begin
        rd_byte = lat_lane ? mem_rdata[15:8] : mem_rdata[7:0];
        if (lat_size) begin
            load_fmt = mem_rdata;
        end else if (lat_unsigned) begin
            load_fmt = {{(WIDTH-8){1'b0}}, rd_byte};
        end else begin
            load_fmt = {{(WIDTH-8){rd_byte[7]}}, rd_byte};
        end
        merged = mem_rdata;
        if (lat_lane) begin
            merged[15:8] = lat_wbyte;
        end else begin
            merged[7:0] = lat_wbyte;
        end
    end

    // Main sequencer. Misaligned halfwords skip memory entirely; loads and
    // byte stores go through READ; halfword stores go straight to WRITE.
    // mem_addr and mem_wdata are only updated when a memory access follows,
    // so they keep their last value while idle or responding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            lat_we       <= 1'b0;
            lat_size     <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_lane     <= 1'b0;
            lat_wbyte    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_we       <= req_we;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_lane     <= ea[0];
                        lat_wbyte    <= req_wdata[7:0];
                        if (req_size && ea[0]) begin
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                            state      <= RESP;
                        end else if (req_we && req_size) begin
                            mem_addr  <= word_addr;
                            mem_wdata <= req_wdata;
                            state     <= WRITE;
                        end else begin
                            mem_addr <= word_addr;
                            state    <= READ;
                        end
                    end
                end
                READ: begin
                    if (lat_we) begin
                        mem_wdata <= merged;
                        state     <= WRITE;
                    end else begin
                        resp_rdata <= load_fmt;
                        resp_err   <= 1'b0;
                        state      <= RESP;
                    end
                end
                WRITE: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    state      <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
